// File: rtl/onalti_dort_demux_pkg.sv
// Shared constants and helpers for the 1-to-16 result distributor.
package onalti_dort_demux_pkg;

  localparam int unsigned N_CH      = 16;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned DEF_WIDTH = 32;

  // Bit offset of channel ch inside a flattened N_CH*width bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

  // Full 4->16 one-hot decode; every select value maps to a real channel.
  function automatic logic [N_CH-1:0] sel_decode(input logic [SEL_W-1:0] s);
    logic [N_CH-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onalti_dort_demux_kanal.sv
// One distributor channel: holding register plus valid flag with consumer ack.
module demux_kanal
  import onalti_dort_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A write in the same cycle as an ack keeps the channel valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~ack;
    if (wr_en) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign free  = ~valid_q | ack;

endmodule

// File: rtl/onalti_dort_demux.sv
// Registered 1-to-16 distributor for ALU results with per-channel valid/ack and optional broadcast.
module onalti_dort_demux
  import onalti_dort_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] dout,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ack,
  output logic [CNT_W-1:0]      wr_count
);

  logic [N_CH-1:0]  free;
  logic [N_CH-1:0]  wr_en;
  logic [N_CH-1:0]  ch_valid;
  logic [WIDTH-1:0] ch_data [N_CH];
  logic             accept;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  always_comb begin
    in_ready   = ~rst & (bcast ? &free : free[sel]);
    accept     = in_valid & in_ready;
    wr_en      = {N_CH{accept}} & (bcast ? {N_CH{1'b1}} : sel_decode(sel));
    wr_count_d = wr_count_q + CNT_W'(accept);
  end

  always_ff @(posedge clk) begin
    if (rst) wr_count_q <= '0;
    else     wr_count_q <= wr_count_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    demux_kanal #(.WIDTH(WIDTH)) u_kanal (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en[i]),
      .din   (din),
      .ack   (out_ack[i]),
      .data  (ch_data[i]),
      .valid (ch_valid[i]),
      .free  (free[i])
    );
  end

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      dout[ch_lsb(i, WIDTH) +: WIDTH] = ch_data[i];
    end
  end

  assign out_valid = ch_valid;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_onalti_dort_demux.sv
// Self-checking bench for onalti_dort_demux: directed table, corner sequences, randomized model check.
module tb_onalti_dort_demux;
  import onalti_dort_demux_pkg::*;

  localparam int W  = 32;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    din;
  logic [3:0]      sel;
  logic            bcast;
  logic            in_valid;
  logic            in_ready;
  logic [16*W-1:0] dout;
  logic [15:0]     out_valid;
  logic [15:0]     out_ack;
  logic [CW-1:0]   wr_count;

  always #5 clk = ~clk;

  onalti_dort_demux #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sel       (sel),
    .bcast     (bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .wr_count  (wr_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: 16 slots, occupancy bits, transaction count.
  logic [W-1:0] m_data [16];
  bit           m_full [16];
  int           m_count;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] model_dout();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*W +: W] = m_data[i];
    return r;
  endfunction

  function automatic logic [15:0] model_valid();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = m_full[i];
    return r;
  endfunction

  // A slot can take a word if it is empty or being drained this cycle.
  function automatic bit model_ready();
    bit ok;
    if (rst) return 1'b0;
    if (!bcast) return !m_full[sel] || out_ack[sel];
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (m_full[i] && !out_ack[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_update(input bit acc);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin m_data[i] = '0; m_full[i] = 0; end
      m_count = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (out_ack[i]) m_full[i] = 0;
      if (acc) begin
        for (int i = 0; i < 16; i++)
          if (bcast || sel == i) begin m_data[i] = din; m_full[i] = 1; end
        m_count = (m_count + 1) % 256;
      end
    end
  endtask

  // Called just after an edge with inputs set; returns DUT in_ready, advances one cycle.
  task automatic step(input bit cmp, output bit rdy);
    bit exp_r;
    #1;
    rdy   = in_ready;
    exp_r = model_ready();
    if (cmp) chk("in_ready", 512'(rdy), 512'(exp_r));
    @(posedge clk);
    model_update(exp_r && in_valid);
    #1;
    if (cmp) begin
      chk("out_valid", 512'(out_valid), 512'(model_valid()));
      chk("wr_count", 512'(wr_count), 512'(m_count));
      chk("dout", 512'(dout), model_dout());
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] din;
    logic [3:0]  sel;
    logic        bcast;
    logic        iv;
    logic [15:0] ack;
    logic        exp_rdy;
    logic [15:0] exp_valid;
    logic [7:0]  exp_cnt;
    int          ch;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  initial begin
    bit rdy;
    bit pending;
    logic [511:0] e;

    vecs[0]  = '{1'b0, 32'hDEADBEEF, 4'd9, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0200, 8'd1, 9, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h11111111, 4'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0208, 8'd2, 3, 32'h11111111};
    vecs[2]  = '{1'b0, 32'h22222222, 4'd3, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0208, 8'd2, 3, 32'h11111111};
    vecs[3]  = '{1'b0, 32'h22222222, 4'd3, 1'b0, 1'b1, 16'h0008, 1'b1, 16'h0208, 8'd3, 3, 32'h22222222};
    vecs[4]  = '{1'b0, 32'h55555555, 4'd5, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0228, 8'd4, 5, 32'h55555555};
    vecs[5]  = '{1'b0, 32'h000000A5, 4'd0, 1'b1, 1'b1, 16'h0208, 1'b0, 16'h0020, 8'd4, 9, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 32'h000000A5, 4'd0, 1'b1, 1'b1, 16'h0020, 1'b1, 16'hFFFF, 8'd5, 5, 32'h000000A5};
    vecs[7]  = '{1'b0, 32'h12345678, 4'd2, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 8'd5, 7, 32'h000000A5};
    vecs[8]  = '{1'b0, 32'h12345678, 4'd2, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h0000, 8'd5, 0, 32'h000000A5};
    vecs[9]  = '{1'b1, 32'hCAFEF00D, 4'd4, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'd0, 0, 32'h00000000};
    vecs[10] = '{1'b1, 32'hCAFEF00D, 4'd4, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'd0, 4, 32'h00000000};

    rst = 1'b1; din = '0; sel = '0; bcast = 1'b0; in_valid = 1'b0; out_ack = '0;
    m_count = 0;
    for (int i = 0; i < 16; i++) begin m_data[i] = '0; m_full[i] = 0; end
    @(posedge clk); #1;
    step(1'b1, rdy);
    rst = 1'b0;

    // Directed table.
    for (int k = 0; k < 11; k++) begin
      rst = vecs[k].rst; din = vecs[k].din; sel = vecs[k].sel; bcast = vecs[k].bcast;
      in_valid = vecs[k].iv; out_ack = vecs[k].ack;
      step(1'b0, rdy);
      chk($sformatf("vec%0d_ready", k), 512'(rdy), 512'(vecs[k].exp_rdy));
      chk($sformatf("vec%0d_valid", k), 512'(out_valid), 512'(vecs[k].exp_valid));
      chk($sformatf("vec%0d_count", k), 512'(wr_count), 512'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d_data", k), 512'(dout[vecs[k].ch*W +: W]), 512'(vecs[k].exp_data));
      if (k == 0) begin
        e = '0;
        e[9*W +: W] = 32'hDEADBEEF;
        chk("vec0_others_zero", 512'(dout), e);
      end
    end
    rst = 1'b0; in_valid = 1'b0; out_ack = '0; bcast = 1'b0;

    // Back-to-back unicast fill of all channels, then a stall.
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s); din = $urandom; in_valid = 1'b1;
      step(1'b1, rdy);
      chk("b2b_ready", 512'(rdy), 512'(1));
    end
    chk("b2b_all_valid", 512'(out_valid), 512'(16'hFFFF));
    chk("b2b_count16", 512'(wr_count), 512'(16));
    sel = 4'd0; din = 32'hBAD0BAD0;
    step(1'b1, rdy);
    chk("b2b_17th_stall", 512'(rdy), 512'(0));
    chk("b2b_17th_count", 512'(wr_count), 512'(16));

    // Drive the count through its wrap with every slot acked each cycle.
    out_ack = 16'hFFFF;
    for (int n = 0; n < 240; n++) begin
      sel = 4'($urandom_range(0, 15)); din = $urandom; in_valid = 1'b1;
      step(1'b1, rdy);
    end
    chk("wrap_to_zero", 512'(wr_count), 512'(0));
    in_valid = 1'b0;
    step(1'b1, rdy);
    step(1'b1, rdy);
    chk("ack_empty_valid", 512'(out_valid), 512'(0));
    out_ack = '0;

    // Randomized traffic; producer holds its request until accepted.
    pending = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!pending) begin
        din      = $urandom;
        sel      = 4'($urandom_range(0, 15));
        bcast    = ($urandom_range(0, 7) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ack = 16'($urandom & $urandom);
      step(1'b1, rdy);
      pending = in_valid && !rdy && !rst;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
